// File: rtl/uart_paddle_ctrl.sv
// Pong command decoder: turns UART receiver bytes into paddle moves, pause and restart.
// Build option: define CASE_FOLD_EN to accept uppercase W/S/O/L/P/R as their lowercase forms.
module uart_paddle_ctrl #(
  parameter int SCREEN_H = 480,
  parameter int PADDLE_H = 80,
  parameter int STEP     = 8,
  parameter int POS_W    = 10
) (
  input  logic             clk25MHz,
  input  logic             rst_n,
  input  logic [7:0]       rx_byte,
  output logic [POS_W-1:0] paddle1_y,
  output logic [POS_W-1:0] paddle2_y,
  output logic             paused,
  output logic             game_reset,
  output logic             cmd_valid,
  output logic             cmd_error
);

  localparam int              Y_MAX  = SCREEN_H - PADDLE_H;
  localparam logic [POS_W:0]   YMAX_W = (POS_W+1)'(Y_MAX);
  localparam logic [POS_W:0]   STEP_W = (POS_W+1)'(STEP);
  localparam logic [POS_W-1:0] Y_MID  = POS_W'(Y_MAX / 2);

  localparam int C_UP1   = 0;
  localparam int C_DN1   = 1;
  localparam int C_UP2   = 2;
  localparam int C_DN2   = 3;
  localparam int C_PAUSE = 4;
  localparam int C_RST   = 5;
  localparam int C_ERR   = 6;

  typedef enum logic [1:0] {IDLE, DECODE, APPLY, WAIT_CLEAR} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [6:0]       cls_q, cls_d;
  logic [POS_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic             paused_q, paused_d;
  logic             grst_q, grst_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  function automatic logic [6:0] classify(input logic [7:0] b);
    logic [7:0] c;
    logic [6:0] r;
    c = b;
`ifdef CASE_FOLD_EN
    if (b >= 8'h41 && b <= 8'h5A) c = b | 8'h20;
`endif
    r = '0;
    case (c)
      8'h77:   r[C_UP1]   = 1'b1;
      8'h73:   r[C_DN1]   = 1'b1;
      8'h6F:   r[C_UP2]   = 1'b1;
      8'h6C:   r[C_DN2]   = 1'b1;
      8'h70:   r[C_PAUSE] = 1'b1;
      8'h72:   r[C_RST]   = 1'b1;
      default: r[C_ERR]   = 1'b1;
    endcase
    return r;
  endfunction

  // One extra bit of headroom so neither direction can wrap before the clamp.
  function automatic logic [POS_W-1:0] move_up(input logic [POS_W-1:0] y);
    logic [POS_W:0] yw;
    yw = {1'b0, y};
    return (yw < STEP_W) ? '0 : POS_W'(yw - STEP_W);
  endfunction

  function automatic logic [POS_W-1:0] move_dn(input logic [POS_W-1:0] y);
    logic [POS_W:0] sum;
    sum = {1'b0, y} + STEP_W;
    return (sum > YMAX_W) ? POS_W'(YMAX_W) : POS_W'(sum);
  endfunction

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    cls_d    = cls_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    paused_d = paused_q;
    grst_d   = 1'b0;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_byte != 8'h00) begin
          cmd_d   = rx_byte;
          state_d = DECODE;
        end
      end
      DECODE: begin
        cls_d   = classify(cmd_q);
        state_d = APPLY;
      end
      APPLY: begin
        if (cls_q[C_ERR]) err_d = 1'b1;
        else              valid_d = 1'b1;
        // Moves while paused still count as valid commands; they just do nothing.
        if (!paused_q) begin
          if (cls_q[C_UP1]) p1_d = move_up(p1_q);
          if (cls_q[C_DN1]) p1_d = move_dn(p1_q);
          if (cls_q[C_UP2]) p2_d = move_up(p2_q);
          if (cls_q[C_DN2]) p2_d = move_dn(p2_q);
        end
        if (cls_q[C_PAUSE]) paused_d = !paused_q;
        if (cls_q[C_RST]) begin
          p1_d     = Y_MID;
          p2_d     = Y_MID;
          paused_d = 1'b0;
          grst_d   = 1'b1;
        end
        state_d = WAIT_CLEAR;
      end
      WAIT_CLEAR: begin
        if (rx_byte == 8'h00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk25MHz) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      cls_q    <= '0;
      p1_q     <= Y_MID;
      p2_q     <= Y_MID;
      paused_q <= 1'b0;
      grst_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cls_q    <= cls_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      paused_q <= paused_d;
      grst_q   <= grst_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign paddle1_y  = p1_q;
  assign paddle2_y  = p2_q;
  assign paused     = paused_q;
  assign game_reset = grst_q;
  assign cmd_valid  = valid_q;
  assign cmd_error  = err_q;

endmodule
